// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// instruction classes, ALU operand classes and instruction field positions.
package proc_pkg;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 28;
  localparam int RS_HI    = 27;
  localparam int RS_LO    = 23;
  localparam int RT_HI    = 22;
  localparam int RT_LO    = 18;
  localparam int RD_HI    = 17;
  localparam int RD_LO    = 13;
  localparam int IMM_HI   = 12;
  localparam int IMM_LO   = 0;
  localparam int FUNCT_HI = 2;
  localparam int FUNCT_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_R    = 4'h1,
    OP_ADDI = 4'h2,
    OP_SUBI = 4'h3,
    OP_BLT  = 4'h4,
    OP_BGT  = 4'h5,
    OP_JMP  = 4'h6,
    OP_LW   = 4'h7,
    OP_SW   = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    BUSCA, DECODIFICA, EXECUTA, MEMORIA, ESCRITA, PARADO
  } estado_e;

  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_BRANCH, CL_JMP, CL_LOAD, CL_STORE, CL_HALT
  } classe_e;

  localparam logic [1:0] ORIG_R    = 2'b00;
  localparam logic [1:0] ORIG_I    = 2'b01;
  localparam logic [1:0] ORIG_CMP  = 2'b10;
  localparam logic [1:0] ORIG_NONE = 2'b11;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_ADD  = 3'b001;
  localparam logic [2:0] SEL_SUB  = 3'b010;

  function automatic logic [31:0] sext_imm(input logic [31:0] instr);
    return {{19{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Single req/ready memory port shared by instruction fetch and data access.
interface unidade_controle_if #(
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/unidade_controle_decodificador.sv
// Combinational decoder: maps an instruction word to its class, the ALU
// operation/operand class it needs in EXECUTA, and its sign-extended immediate.
module decodificador
  import proc_pkg::*;
(
  input  logic [31:0] instr,
  output classe_e     classe,
  output logic [2:0]  selec,
  output logic [1:0]  orig_ula,
  output logic [31:0] imed
);

  logic unused_campos;
  assign unused_campos = ^instr[RS_HI:RD_LO];

  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    classe   = CL_NOP;
    selec    = SEL_NONE;
    orig_ula = ORIG_NONE;
    case (instr[OPC_HI:OPC_LO])
      OP_R:    begin classe = CL_ALU;    orig_ula = ORIG_R;   selec = instr[FUNCT_HI:FUNCT_LO]; end
      OP_ADDI: begin classe = CL_ALU;    orig_ula = ORIG_I;   selec = SEL_ADD; end
      OP_SUBI: begin classe = CL_ALU;    orig_ula = ORIG_I;   selec = SEL_SUB; end
      OP_BLT:  begin classe = CL_BRANCH; orig_ula = ORIG_CMP; selec = SEL_ADD; end
      OP_BGT:  begin classe = CL_BRANCH; orig_ula = ORIG_CMP; selec = SEL_SUB; end
      OP_JMP:  classe = CL_JMP;
      OP_LW:   begin classe = CL_LOAD;   orig_ula = ORIG_I;   selec = SEL_ADD; end
      OP_SW:   begin classe = CL_STORE;  orig_ula = ORIG_I;   selec = SEL_ADD; end
      OP_HALT: classe = CL_HALT;
      default: classe = CL_NOP;
    endcase
  end

  assign imed = sext_imm(instr);

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: fetch/decode/execute/memory/write-back FSM, PC and
// optional performance counters (enabled by UNIDADE_CONTROLE_CONTADORES_EN).
module unidade_controle
  import proc_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  unidade_controle_if.master bus,
  output logic [4:0]        reg_rs,
  output logic [4:0]        reg_rt,
  output logic [4:0]        reg_rd,
  input  logic [31:0]       rs_dado,
  output logic              reg_we,
  output logic [4:0]        reg_waddr,
  output logic [31:0]       reg_wdata,
  output logic [31:0]       imed,
  output logic [2:0]        selec,
  output logic [1:0]        origULA,
  input  logic [31:0]       result,
  input  logic              zero,
  input  logic              negativo,
  output logic [ADDR_W-1:0] pc,
  output logic              parado,
  output logic [31:0]       ciclos,
  output logic [31:0]       instrucoes
);

  estado_e           estado, estado_prox;
  logic [31:0]       instr, res_q, wdata_q;
  classe_e           classe;
  logic [2:0]        dec_selec;
  logic [1:0]        dec_orig;
  logic              ultimo, salto, req_c, we_c;
  logic [ADDR_W-1:0] addr_c, pc_prox;

  logic unused_ok;
  assign unused_ok = zero;

  decodificador u_dec (
    .instr    (instr),
    .classe   (classe),
    .selec    (dec_selec),
    .orig_ula (dec_orig),
    .imed     (imed)
  );

  always_comb begin
    estado_prox = estado;
    ultimo      = 1'b0;
    req_c       = 1'b0;
    we_c        = 1'b0;
    addr_c      = pc;
    selec       = SEL_NONE;
    origULA     = ORIG_NONE;
    unique case (estado)
      BUSCA: begin
        req_c = 1'b1;
        if (bus.mem_ready) estado_prox = DECODIFICA;
      end
      DECODIFICA: begin
        case (classe)
          CL_NOP, CL_JMP: begin estado_prox = BUSCA;  ultimo = 1'b1; end
          CL_HALT:        begin estado_prox = PARADO; ultimo = 1'b1; end
          default:        estado_prox = EXECUTA;
        endcase
      end
      EXECUTA: begin
        selec   = dec_selec;
        origULA = dec_orig;
        case (classe)
          CL_ALU:            estado_prox = ESCRITA;
          CL_LOAD, CL_STORE: estado_prox = MEMORIA;
          default:           begin estado_prox = BUSCA; ultimo = 1'b1; end
        endcase
      end
      MEMORIA: begin
        req_c  = 1'b1;
        we_c   = (classe == CL_STORE);
        addr_c = res_q[ADDR_W-1:0];
        if (bus.mem_ready) begin
          estado_prox = (classe == CL_STORE) ? BUSCA : ESCRITA;
          ultimo      = (classe == CL_STORE);
        end
      end
      ESCRITA: begin
        estado_prox = BUSCA;
        ultimo      = 1'b1;
      end
      PARADO:  estado_prox = PARADO;
      default: estado_prox = BUSCA;
    endcase
  end

  // Branches are only resolved in EXECUTA, JMP only in DECODIFICA, so the
  // flag is meaningful exactly when the instruction retires.
  assign salto   = (classe == CL_JMP) || ((classe == CL_BRANCH) && negativo);
  assign pc_prox = pc + ADDR_W'(1) + (salto ? imed[ADDR_W-1:0] : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado  <= BUSCA;
      instr   <= '0;
      res_q   <= '0;
      wdata_q <= '0;
      pc      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      estado <= estado_prox;
      if (estado == BUSCA && bus.mem_ready) instr <= bus.mem_rdata;
      if (estado == EXECUTA) begin
        res_q   <= result;
        wdata_q <= rs_dado;
      end
      if (estado == MEMORIA && bus.mem_ready && classe == CL_LOAD) res_q <= bus.mem_rdata;
      if (ultimo) pc <= pc_prox;
    end
  end

  // Gating with rst_n drops the request as soon as reset asserts, even though
  // the reset state itself is BUSCA.
  assign bus.mem_req   = req_c & rst_n;
  assign bus.mem_we    = we_c & rst_n;
  assign bus.mem_addr  = addr_c;
  assign bus.mem_wdata = wdata_q;

  assign reg_rs    = instr[RS_HI:RS_LO];
  assign reg_rt    = instr[RT_HI:RT_LO];
  assign reg_rd    = instr[RD_HI:RD_LO];
  assign reg_waddr = instr[RS_HI:RS_LO];
  assign reg_we    = (estado == ESCRITA);
  assign reg_wdata = res_q;
  assign parado    = (estado == PARADO);

`ifdef UNIDADE_CONTROLE_CONTADORES_EN
  logic [31:0] ciclos_q, instrucoes_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciclos_q     <= '0;
      instrucoes_q <= '0;
    end else begin
      if (!parado) ciclos_q <= ciclos_q + 32'd1;
      if (ultimo)  instrucoes_q <= instrucoes_q + 32'd1;
    end
  end

  assign ciclos     = ciclos_q;
  assign instrucoes = instrucoes_q;
`else
  assign ciclos     = '0;
  assign instrucoes = '0;
`endif

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multi-cycle control unit driving the processor's 32-bit ALU (`selec`, `origULA`) and register file. It fetches and decodes instructions over a single req/ready memory port, sequences execute, memory and write-back, and resolves BLT/BGT from the ALU `negativo` flag. It sits between instruction/data memory, the register file and the ALU.

## Interface
- `ADDR_W`, default 16: word-address width of `pc` and `mem_addr`.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  write strobe, qualified by `mem_req`.
- `mem_addr`  out  ADDR_W  word address.
- `mem_wdata`  out  32  store data.
- `mem_rdata`  in  32  fetch/load data, valid with `mem_ready`.
- `mem_ready`  in  1  completes the current request on this edge.
- `reg_rs`, `reg_rt`, `reg_rd`  out  5 each  register-file read addresses.
- `rs_dado`  in  32  register-file read data for `reg_rs`, used for SW.
- `reg_we`  out  1  register write enable, single-cycle pulse.
- `reg_waddr`  out  5  write address; always equal to the `rs` field.
- `reg_wdata`  out  32  write data.
- `imed`  out  32  sign-extended `instr[12:0]`.
- `selec`  out  3  ALU operation select.
- `origULA`  out  2  ALU operand class.
- `result`  in  32  ALU result.
- `zero`  in  1  ALU zero flag; unused.
- `negativo`  in  1  ALU sign flag.
- `pc`  out  ADDR_W  current instruction address.
- `parado`  out  1  high once HALT has executed.
- `ciclos`, `instrucoes`  out  32 each  performance counters; see Configuration.

## Operation
- Fields: opcode `[31:28]`, rs `[27:23]`, rt `[22:18]`, rd `[17:13]`, imm `[12:0]`, funct `[2:0]`.
- Opcodes:
  - 0x0 NOP.
  - 0x1 R-type: `origULA`=00, `selec`=funct, reg[rs]←result.
  - 0x2 ADDI: 01/001.
  - 0x3 SUBI: 01/010.
  - 0x4 BLT: 10/001, taken if `negativo`.
  - 0x5 BGT: 10/010, taken if `negativo`.
  - 0x6 JMP.
  - 0x7 LW: 01/001 address, reg[rs]←mem.
  - 0x8 SW: 01/001 address, mem←`rs_dado`.
  - 0xF HALT.
  - Any other opcode executes as NOP.
- States:
  - BUSCA: `mem_req`=1, `mem_we`=0, `mem_addr`=pc. On `mem_ready`, latch instr → DECODIFICA.
  - DECODIFICA: drive read addresses → EXECUTA. NOP, JMP and HALT skip EXECUTA and go directly to the next state.
  - EXECUTA: `selec`/`origULA` valid; latch `result` into `res_q`.
    - R/ADDI/SUBI → ESCRITA.
    - LW/SW → MEMORIA.
    - Branches → BUSCA.
  - MEMORIA: `mem_req`=1, `mem_addr`=`res_q[ADDR_W-1:0]`, `mem_we`=SW. Wait for `mem_ready`.
    - LW latches `mem_rdata` → ESCRITA.
    - SW → BUSCA.
  - ESCRITA: `reg_we`=1, `reg_wdata`=`res_q` (or load data) → BUSCA.
  - PARADO: terminal. No requests. `parado`=1. Left only by reset.
- PC update:
  - Taken branch and JMP: pc ← pc+1+sext(imm).
  - All other instructions: pc ← pc+1.
  - Update occurs on the instruction's last cycle.
  - Arithmetic is modulo 2^ADDR_W (wrap-around).
- Outside EXECUTA: `selec`=000, `origULA`=11, so the ALU outputs 0.

## Timing
- Reset values: pc=0, state BUSCA, instr=0, `res_q`=0, `reg_we`=0, `mem_we`=0, `parado`=0, counters=0. `mem_req`=1 on the first cycle after `rst_n` deasserts.
- Reset mid-operation: all state clears immediately and asynchronously. `mem_req` drops while `rst_n` is low.
- With zero wait states, cycles per instruction:
  - R/ADDI/SUBI: 4.
  - Branch: 3.
  - NOP/JMP: 2.
  - LW: 5.
  - SW: 4.
- Each memory wait cycle adds one cycle.
- While `mem_ready`=0, `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are held stable.
- `mem_ready` while `mem_req`=0 is ignored.

## Configuration
- `UNIDADE_CONTROLE_CONTADORES_EN` defined:
  - `ciclos` increments every cycle while not `parado`.
  - `instrucoes` increments on each instruction's final cycle, including HALT.
- Undefined: both ports are tied to 0 and no counter flops exist.

## Structure
- Shared package `proc_pkg`:
  - opcode enum.
  - state enum.
  - `origULA` constants: R=00, I=01, CMP=10, NONE=11.
  - field bit positions.
- Sub-module `decodificador`: combinational instr → class, `selec`, `origULA`, `imed`.
- The FSM, PC and counters remain in `unidade_controle`.

## Test plan
- Reset; memory at addr 0 returns 0x2 ADDI rs=1, rt=0, imm=5, with `result`=5 modelled → `reg_we` pulse, waddr=1, wdata=5, in cycle 4; pc=1.
- BLT at pc=10, imm=-3, `negativo`=1 → next fetch at 8. With `negativo`=0 → next fetch at 11.
- `mem_ready` delayed 3 cycles during fetch → `mem_addr` and `mem_req` stable throughout; instruction completes 3 cycles later.
- SW with `result`=0x20 and `rs_dado`=0xDEADBEEF → MEMORIA drives addr 0x20, `mem_we`=1, wdata 0xDEADBEEF. LW from the same address → reg written with `mem_rdata`.
- JMP at pc=0xFFFF (ADDR_W=16), imm=0 → pc wraps to 0. HALT → `parado`=1, no further `mem_req`. With the macro defined, `instrucoes` is frozen.
- `rst_n` asserted during MEMORIA wait → `mem_req` drops asynchronously. After release, fetch restarts at pc=0.
